// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the 2-read / 1-write register file.
// Address widths come from clog2_safe so that tiny register files still get a 1-bit address.
package regfile_pkg;

  localparam int DEF_W     = 16;
  localparam int DEF_DEPTH = 16;

  // Wide enough for any practical data width; users slice [W-1:0].
  localparam int MAX_W = 1024;
  localparam logic [MAX_W-1:0] ZERO_WORD = '0;

  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_2r1w_mux_n1.sv
// N:1 word selector; any select value >= N yields an all-zero word.
module mux_n1
  import regfile_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int N  = DEF_DEPTH,
  parameter int SW = clog2_safe(N)
) (
  input  logic [N-1:0][W-1:0] din,
  input  logic [SW-1:0]       sel,
  output logic [W-1:0]        dout
);

  // Compare-per-entry keeps out-of-range selects naturally at zero for non-power-of-two N.
  always_comb begin
    dout = ZERO_WORD[W-1:0];
    for (int i = 0; i < N; i++)
      if (sel == SW'(i)) dout = din[i];
  end

endmodule

// File: rtl/regfile_2r1w.sv
// Parametrised register file with two read ports, one write port, optional
// write-to-read bypass, optional registered read stage and optional zero register.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter bit BYPASS    = 1'b1,
  parameter bit READ_REG  = 1'b0,
  parameter bit ZERO_REG0 = 1'b0,
  localparam int AW       = clog2_safe(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [W-1:0]  rdata1,
  output logic [W-1:0]  rdata2,
  output logic          rvalid
);

  logic [DEPTH-1:0][W-1:0] regs;
  logic [W-1:0]            sel1, sel2, rv1, rv2;
  logic                    wr_ok;

  // Zero-extend the address so the range check stays meaningful when DEPTH == 2**AW.
  assign wr_ok = we && !reset
              && ({1'b0, waddr} < (AW+1)'(DEPTH))
              && !(ZERO_REG0 && waddr == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_ok && waddr == AW'(i)) regs[i] <= wdata;
    end
  end

  mux_n1 #(.W(W), .N(DEPTH), .SW(AW)) u_mux1 (.din(regs), .sel(raddr1), .dout(sel1));
  mux_n1 #(.W(W), .N(DEPTH), .SW(AW)) u_mux2 (.din(regs), .sel(raddr2), .dout(sel2));

  // Out-of-range addresses are already zero from the selector; wr_ok implies in-range.
  function automatic logic [W-1:0] read_val(input logic [AW-1:0] a, input logic [W-1:0] stored);
    if (ZERO_REG0 && a == '0) return '0;
    if (BYPASS && wr_ok && waddr == a) return wdata;
    return stored;
  endfunction

  always_comb begin
    rv1 = read_val(raddr1, sel1);
    rv2 = read_val(raddr2, sel2);
  end

  generate
    if (READ_REG) begin : g_rd_reg
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rdata1 <= '0;
          rdata2 <= '0;
          rvalid <= 1'b0;
        end else if (re) begin
          rdata1 <= rv1;
          rdata2 <= rv2;
          rvalid <= 1'b1;
        end else begin
          rvalid <= 1'b0;
        end
      end
    end else begin : g_rd_comb
      logic unused_re;
      assign unused_re = re;
      assign rdata1    = rv1;
      assign rdata2    = rv2;
      assign rvalid    = 1'b1;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_2r1w.sv
// Drives four register-file configurations from one stimulus stream and checks them
// against a behavioural array model every cycle, plus directed literal expectations.
module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        reset;
  logic        we, re;
  logic [3:0]  waddr, raddr1, raddr2;
  logic [15:0] wdata;

  logic [15:0] a_r1, a_r2, b_r1, b_r2, c_r1, c_r2, d_r1, d_r2;
  logic        a_v, b_v, c_v, d_v;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  // A: no bypass, comb read.  B: bypass, comb read.  C: bypass, registered read.
  // D: 12 entries, bypass, zero register.
  regfile_2r1w #(.W(16), .DEPTH(16), .BYPASS(0), .READ_REG(0), .ZERO_REG0(0)) u_a (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(a_r1), .rdata2(a_r2), .rvalid(a_v));
  regfile_2r1w #(.W(16), .DEPTH(16), .BYPASS(1), .READ_REG(0), .ZERO_REG0(0)) u_b (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(b_r1), .rdata2(b_r2), .rvalid(b_v));
  regfile_2r1w #(.W(16), .DEPTH(16), .BYPASS(1), .READ_REG(1), .ZERO_REG0(0)) u_c (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(c_r1), .rdata2(c_r2), .rvalid(c_v));
  regfile_2r1w #(.W(16), .DEPTH(12), .BYPASS(1), .READ_REG(0), .ZERO_REG0(1)) u_d (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(d_r1), .rdata2(d_r2), .rvalid(d_v));

  // Behavioural model: plain arrays of register contents plus the captured read pair.
  logic [15:0] m16 [16];
  logic [15:0] m12 [12];
  logic [15:0] mc1, mc2;
  logic        mcv;

  function automatic logic [15:0] rv_m(input int depth, input bit zero, input bit byp,
                                       input logic [3:0] a);
    if (int'(a) >= depth) return 16'h0;
    if (zero && a == 4'd0) return 16'h0;
    if (byp && we && !reset && waddr == a && int'(waddr) < depth && !(zero && waddr == 4'd0))
      return wdata;
    if (depth == 16) return m16[a];
    return m12[a];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) m16[i] <= 16'h0;
      for (int i = 0; i < 12; i++) m12[i] <= 16'h0;
      mc1 <= 16'h0;
      mc2 <= 16'h0;
      mcv <= 1'b0;
    end else begin
      if (we) m16[waddr] <= wdata;
      if (we && waddr < 4'd12 && waddr != 4'd0) m12[waddr] <= wdata;
      if (re) begin
        mc1 <= rv_m(16, 0, 1, raddr1);
        mc2 <= rv_m(16, 0, 1, raddr2);
        mcv <= 1'b1;
      end else begin
        mcv <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("A.r1", a_r1, rv_m(16, 0, 0, raddr1));
      chk("A.r2", a_r2, rv_m(16, 0, 0, raddr2));
      chk("B.r1", b_r1, rv_m(16, 0, 1, raddr1));
      chk("B.r2", b_r2, rv_m(16, 0, 1, raddr2));
      chk("D.r1", d_r1, rv_m(12, 1, 1, raddr1));
      chk("D.r2", d_r2, rv_m(12, 1, 1, raddr2));
      chk("C.r1", c_r1, mc1);
      chk("C.r2", c_r2, mc2);
      chk("C.v", {15'h0, c_v}, {15'h0, mcv});
      chk("ABD.v", {13'h0, a_v, b_v, d_v}, 16'h0007);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [15:0] exp_d;
    reset = 1'b1; we = 1'b0; re = 1'b0;
    waddr = 4'd0; wdata = 16'h0; raddr1 = 4'd0; raddr2 = 4'd0;
    step(); step();
    reset = 1'b0;
    started = 1'b1;

    // Preload every register with all-ones, capture a registered read, then reset mid-cycle.
    for (int i = 0; i < 16; i++) begin
      step();
      we = 1'b1; waddr = 4'(i); wdata = 16'hFFFF;
    end
    step();
    we = 1'b0; re = 1'b1; raddr1 = 4'd4; raddr2 = 4'd5;
    step();
    re = 1'b0;
    #1;
    chk("pre.A.r1", a_r1, 16'hFFFF);
    chk("pre.C.r1", c_r1, 16'hFFFF);
    chk("pre.C.v", {15'h0, c_v}, 16'h0001);
    reset = 1'b1;
    #1;
    chk("rst.A.r1", a_r1, 16'h0);
    chk("rst.B.r2", b_r2, 16'h0);
    chk("rst.C.r1", c_r1, 16'h0);
    chk("rst.C.v", {15'h0, c_v}, 16'h0);
    for (int i = 0; i < 16; i++) begin
      step();
      raddr1 = 4'(i); raddr2 = 4'(15 - i);
      #1;
      chk("rst.A.all", a_r1, 16'h0);
      chk("rst.B.all", b_r2, 16'h0);
    end
    step();
    reset = 1'b0;

    // Same-cycle write/read of reg5: no-bypass sees old data, bypass sees new.
    step();
    we = 1'b1; waddr = 4'd5; wdata = 16'hA5A5; raddr1 = 4'd5; raddr2 = 4'd5;
    #1;
    chk("wr.A.old", a_r1, 16'h0000);
    chk("wr.B.byp", b_r1, 16'hA5A5);
    step();
    we = 1'b0;
    #1;
    chk("wr.A.new", a_r1, 16'hA5A5);

    // Bypass on both ports for the same address.
    step();
    we = 1'b1; waddr = 4'd3; wdata = 16'h1234; raddr1 = 4'd3; raddr2 = 4'd3;
    #1;
    chk("byp.B.r1", b_r1, 16'h1234);
    chk("byp.B.r2", b_r2, 16'h1234);
    chk("byp.A.r1", a_r1, 16'h0000);

    // Registered read: one-cycle latency, hold on re=0, later write does not disturb.
    step();
    waddr = 4'd7; wdata = 16'h00FF;
    step();
    we = 1'b0; re = 1'b1; raddr1 = 4'd7; raddr2 = 4'd0;
    #1;
    chk("rr.C.v0", {15'h0, c_v}, 16'h0);
    step();
    re = 1'b0; we = 1'b1; waddr = 4'd7; wdata = 16'hAAAA; raddr1 = 4'd3;
    #1;
    chk("rr.C.r1", c_r1, 16'h00FF);
    chk("rr.C.r2", c_r2, 16'h0000);
    chk("rr.C.v1", {15'h0, c_v}, 16'h0001);
    step();
    we = 1'b0;
    #1;
    chk("rr.C.hold", c_r1, 16'h00FF);
    chk("rr.C.vdrop", {15'h0, c_v}, 16'h0);

    // Zero register and out-of-range write on the 12-entry instance.
    step();
    we = 1'b1; waddr = 4'd0; wdata = 16'hBEEF;
    step();
    waddr = 4'd13;
    step();
    we = 1'b0; raddr1 = 4'd0; raddr2 = 4'd13;
    #1;
    chk("zr.D.r0", d_r1, 16'h0);
    chk("zr.D.r13", d_r2, 16'h0);
    chk("zr.A.r0", a_r1, 16'hBEEF);
    chk("zr.A.r13", a_r2, 16'hBEEF);
    for (int i = 1; i < 12; i++) begin
      step();
      raddr1 = 4'(i);
      #1;
      exp_d = (i == 3) ? 16'h1234 : (i == 5) ? 16'hA5A5 : (i == 7) ? 16'hAAAA : 16'h0;
      chk("zr.D.keep", d_r1, exp_d);
    end

    // Reset arriving with a write: the write is lost; first edge after release writes.
    step();
    reset = 1'b1; we = 1'b1; waddr = 4'd2; wdata = 16'h5555; raddr1 = 4'd2; raddr2 = 4'd2;
    step();
    reset = 1'b0;
    #1;
    chk("rw.A.lost", a_r1, 16'h0);
    step();
    we = 1'b0;
    #1;
    chk("rw.A.land", a_r1, 16'h5555);
    chk("rw.D.land", d_r2, 16'h5555);

    // Mixed traffic checked by the per-cycle model compare.
    for (int i = 0; i < 60; i++) begin
      step();
      we = 1'($urandom_range(0, 1)); re = 1'($urandom_range(0, 1));
      waddr = 4'($urandom_range(0, 15)); wdata = 16'($urandom);
      raddr1 = 4'($urandom_range(0, 15));
      raddr2 = (i % 4 == 0) ? waddr : 4'($urandom_range(0, 15));
    end
    step();
    we = 1'b0; re = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
